coherent_bus_arbiter: RTL and testbench
=======================================

Name: coherent_bus_arbiter

Overview:
- N-core successor to the two-core memory controller.
- Arbitrates instruction and data traffic from CPUS L1 caches onto one RAM port.
- Runs the MSI snoop/invalidate protocol over those caches, including cache-to-cache forwarding with concurrent RAM writeback.
- Sits between cache_control_if-style cache ports and the RAM model. Fairness is round-robin per class, with a bounded-starvation guarantee for instruction fetches.

Parameters:
CPUS, 2, number of cores (2..8); CW = max(1, $clog2(CPUS))
WORD_W, 32, data/address word width (word_t)
DSTARVE, 4, max consecutive data grants while any iREN is pending before one instruction grant is forced

Ports:
CLK  in  1  clock; all state updates on rising edge
nRST  in  1  asynchronous active-low reset
iREN  in  CPUS  per-core instruction read request
iaddr  in  CPUS*WORD_W  per-core instruction address
dREN  in  CPUS  per-core data read (fill) request
dWEN  in  CPUS  per-core data write (writeback) request
daddr  in  CPUS*WORD_W  per-core data address
dstore  in  CPUS*WORD_W  per-core store / snoop-supply data
cctrans  in  CPUS  core requests a coherence transaction (requester), or acknowledges a snoop hit (snooped core)
ccwrite  in  CPUS  requester: wants M (BusRdX); snooped core: holds line in M and supplies it
iwait  out  CPUS  low for exactly the completion cycle of that core's fetch
dwait  out  CPUS  low for exactly the completion cycle of that core's data op, or of its supply
iload  out  CPUS*WORD_W  instruction data (ramload broadcast)
dload  out  CPUS*WORD_W  data to requester (ramload, or forwarded dstore)
ccwait  out  CPUS  snooped cores must stall and respond
ccinv  out  CPUS  snooped cores invalidate the line at ccsnoopaddr
ccsnoopaddr  out  CPUS*WORD_W  snoop address, same value to all snooped cores
ramstate  in  2  FREE/BUSY/ACCESS/ERROR
ramload  in  WORD_W  RAM read data
ramaddr, ramstore  out  WORD_W  RAM address / write data
ramREN, ramWEN  out  1  RAM enables; never both high

Behaviour:
- Reset values: state=IDLE, rr_d=0, rr_i=0, dcount=0, gnt=0. Outputs: iwait/dwait all 1; ccwait/ccinv 0; ccsnoopaddr 0; ramREN/ramWEN 0; ramaddr/ramstore 0.
- A reset asserted mid-transaction aborts it: RAM enables drop asynchronously and no completion is signalled.
- "Done" means ramstate==ACCESS. FREE, BUSY and ERROR all hold the current state; ERROR never completes.
- Waits default to 1 for every core in every state. A wait is deasserted only on the done cycle, and only for the cores named below.
- IDLE:
  - Data class = cores with dREN|dWEN. Instruction class = cores with iREN.
  - Grant goes to data unless (dcount==DSTARVE and instruction class non-empty).
  - Within a class: first requester at or after that class's pointer, wrapping modulo CPUS.
  - Register gnt, then go to:
    - DWB if dWEN[gnt].
    - SNOOP if dREN[gnt]&cctrans[gnt].
    - INV if cctrans[gnt]&!dREN[gnt] (S->M upgrade).
    - DRD if dREN[gnt] only.
    - IRD for an instruction grant.
  - No request: stay in IDLE. Arbitration costs 1 cycle.
- IRD: ramREN=1, ramaddr=iaddr[gnt]. On done: iwait[gnt]=0, go to IDLE.
- DRD: ramREN=1, ramaddr=daddr[gnt], dload[gnt]=ramload. On done: dwait[gnt]=0, go to IDLE.
- DWB: ramWEN=1, ramaddr=daddr[gnt], ramstore=dstore[gnt]. On done: dwait[gnt]=0, go to IDLE.
- SNOOP (exactly 1 cycle):
  - For all i!=gnt: ccwait[i]=1, ccsnoopaddr[i]=daddr[gnt], ccinv[i]=ccwrite[gnt].
  - sup = lowest i!=gnt with cctrans[i]&ccwrite[i].
  - sup exists: go to C2C. Otherwise go to DRD, with ccwait/ccinv held through DRD.
- C2C:
  - ccwait/snoop outputs held.
  - ramWEN=1, ramaddr=daddr[gnt], ramstore=dstore[sup], dload[gnt]=dstore[sup].
  - On done: dwait[gnt]=0 and dwait[sup]=0 in the same cycle, go to IDLE.
- INV (exactly 1 cycle): ccwait=ccinv=1 for all i!=gnt, ccsnoopaddr=daddr[gnt]. Then dwait[gnt]=0, go to IDLE.
- On every return to IDLE: the granted class's pointer becomes gnt+1 mod CPUS.
  - dcount increments on each data completion while any iREN is pending (saturates at DSTARVE).
  - dcount clears on an instruction completion, or when no iREN is pending.
- Requests are level-sensitive. A core drops its request after its completion cycle. A request dropped mid-op is ignored until done.
- CPUS=1: SNOOP/INV issue no ccwait and complete normally.

Decomposition:
- Shared package (cpu_types_pkg): ramstate_t (FREE/BUSY/ACCESS/ERROR) and word_t already exist there. Add busarb_state_t {IDLE, IRD, DRD, DWB, SNOOP, C2C, INV}.
- One sub-module, rr_arbiter: parameter N; inputs req[N] and ptr; outputs gnt and valid. Instantiated twice (data and instruction classes).

Test Plan:
- CPUS=4, iREN=4'b1111, RAM 2-cycle latency -> grants 0,1,2,3,0. Each iwait low for 1 cycle only; iload equals ramload.
- Core 2 dWEN and core 1 iREN in the same cycle -> DWB to core 2 first (ramWEN=1, ramaddr=daddr[2]), then IRD for core 1.
- DSTARVE=4, cores 0..3 continuously requesting dREN, core 1 iREN held -> IRD for core 1 is granted after exactly 4 data completions.
- Core 0 dREN+cctrans+ccwrite=1 @0x100; core 3 cctrans+ccwrite=1, dstore=0xDEAD -> C2C. ccinv to cores 1..3, dload[0]=0xDEAD, RAM written 0xDEAD@0x100, dwait[0] and dwait[3] low in the same cycle.
- Core 1 cctrans=1, dREN=0 -> INV. ccinv=4'b1101 for 1 cycle, no RAM enable, dwait[1] low the next cycle.
- ramstate=ERROR during DRD -> dwait stays 1, state held. nRST pulse -> all outputs return to reset values in the same cycle.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types.
//   word_t          : one data/address word
//   ramstate_t      : RAM port status (FREE/BUSY/ACCESS/ERROR)
//   busarb_state_t  : coherent_bus_arbiter FSM states
//   clog2_min1()    : index width that stays >= 1 for single-entry arrays
package cpu_types_pkg;
  localparam int WORD_BITS = 32;
  typedef logic [WORD_BITS-1:0] word_t;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

  typedef enum logic [2:0] {IDLE, IRD, DRD, DWB, SNOOP, C2C, INV} busarb_state_t;

  function automatic int clog2_min1(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester at or after ptr, wrapping modulo N.
//   req   : request vector
//   ptr   : highest-priority index this round (< N)
//   gnt   : chosen index (0 when no request)
//   valid : any request present
module rr_arbiter #(
  parameter int  N  = 2,
  localparam int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] ptr,
  output logic [CW-1:0] gnt,
  output logic          valid
);
  always_comb begin
    gnt   = '0;
    valid = |req;
    // Scan from farthest to nearest so the nearest requester wins last.
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) gnt = CW'((int'(ptr) + k) % N);
    end
  end
endmodule

// File: rtl/coherent_bus_arbiter.sv
// N-core MSI bus arbiter: round-robin per class (instruction / data) onto one
// RAM port, snoop/invalidate fan-out, and cache-to-cache forwarding with a
// concurrent RAM writeback of the supplied line.
//   CLK/nRST                 : clock, async active-low reset
//   iREN/iaddr               : per-core instruction fetch
//   dREN/dWEN/daddr/dstore   : per-core data fill / writeback / supply data
//   cctrans/ccwrite          : coherence request (requester) or snoop ack
//   iwait/dwait              : low only on the completion cycle
//   iload/dload              : returned data
//   ccwait/ccinv/ccsnoopaddr : snoop outputs to non-granted cores
//   ramstate/ramload         : RAM status and read data
//   ramREN/ramWEN/ramaddr/ramstore : RAM request
module coherent_bus_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS    = 2,
  parameter int WORD_W  = 32,
  parameter int DSTARVE = 4
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic [CPUS-1:0]              iREN,
  input  logic [CPUS-1:0][WORD_W-1:0]  iaddr,
  input  logic [CPUS-1:0]              dREN,
  input  logic [CPUS-1:0]              dWEN,
  input  logic [CPUS-1:0][WORD_W-1:0]  daddr,
  input  logic [CPUS-1:0][WORD_W-1:0]  dstore,
  input  logic [CPUS-1:0]              cctrans,
  input  logic [CPUS-1:0]              ccwrite,
  output logic [CPUS-1:0]              iwait,
  output logic [CPUS-1:0]              dwait,
  output logic [CPUS-1:0][WORD_W-1:0]  iload,
  output logic [CPUS-1:0][WORD_W-1:0]  dload,
  output logic [CPUS-1:0]              ccwait,
  output logic [CPUS-1:0]              ccinv,
  output logic [CPUS-1:0][WORD_W-1:0]  ccsnoopaddr,
  input  ramstate_t                    ramstate,
  input  logic [WORD_W-1:0]            ramload,
  output logic [WORD_W-1:0]            ramaddr,
  output logic [WORD_W-1:0]            ramstore,
  output logic                         ramREN,
  output logic                         ramWEN
);
  localparam int CW  = clog2_min1(CPUS);
  localparam int DCW = $clog2(DSTARVE + 1);

  busarb_state_t  state_q, state_d;
  logic [CW-1:0]  gnt_q, gnt_d, sup_q, sup_d;
  logic [CW-1:0]  rrd_q, rrd_d, rri_q, rri_d;
  logic [DCW-1:0] dcount_q, dcount_d;
  logic           snp_q, snp_d;   // DRD entered from SNOOP: keep snoop outputs up
  logic           inv_q, inv_d;   // ccwrite of the requester, latched in SNOOP

  logic [CPUS-1:0] dreq;
  logic [CW-1:0]   d_gnt, i_gnt, sup_c;
  logic            d_vld, i_vld, sup_found, data_cpl, done;
  logic            snoop_on, snoop_inv;

  function automatic logic [CW-1:0] wrap_inc(logic [CW-1:0] v);
    return (int'(v) == CPUS - 1) ? '0 : v + 1'b1;
  endfunction

  assign done = (ramstate == ACCESS);
  // cctrans without dREN/dWEN is an S->M upgrade, so it joins the data class;
  // snoop acks only appear outside IDLE and are never arbitrated.
  assign dreq = dREN | dWEN | cctrans;

  rr_arbiter #(.N(CPUS)) u_arb_d (.req(dreq), .ptr(rrd_q), .gnt(d_gnt), .valid(d_vld));
  rr_arbiter #(.N(CPUS)) u_arb_i (.req(iREN), .ptr(rri_q), .gnt(i_gnt), .valid(i_vld));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      sup_q    <= '0;
      rrd_q    <= '0;
      rri_q    <= '0;
      dcount_q <= '0;
      snp_q    <= 1'b0;
      inv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      sup_q    <= sup_d;
      rrd_q    <= rrd_d;
      rri_q    <= rri_d;
      dcount_q <= dcount_d;
      snp_q    <= snp_d;
      inv_q    <= inv_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    sup_d    = sup_q;
    rrd_d    = rrd_q;
    rri_d    = rri_q;
    dcount_d = dcount_q;
    snp_d    = snp_q;
    inv_d    = inv_q;
    data_cpl = 1'b0;
    // Lowest-numbered snooped core holding the line in M.
    sup_found = 1'b0;
    sup_c     = '0;
    for (int i = CPUS - 1; i >= 0; i--) begin
      if (i != int'(gnt_q) && cctrans[i] && ccwrite[i]) begin
        sup_found = 1'b1;
        sup_c     = CW'(i);
      end
    end
    case (state_q)
      IDLE: begin
        snp_d = 1'b0;
        if (i_vld && (!d_vld || dcount_q == DCW'(DSTARVE))) begin
          gnt_d   = i_gnt;
          state_d = IRD;
        end else if (d_vld) begin
          gnt_d = d_gnt;
          if (dWEN[d_gnt])                          state_d = DWB;
          else if (dREN[d_gnt] && cctrans[d_gnt])   state_d = SNOOP;
          else if (cctrans[d_gnt])                  state_d = INV;
          else                                      state_d = DRD;
        end
      end
      IRD: begin
        if (done) begin
          state_d  = IDLE;
          rri_d    = wrap_inc(gnt_q);
          dcount_d = '0;
        end
      end
      DRD, DWB, C2C: data_cpl = done;
      SNOOP: begin
        inv_d = ccwrite[gnt_q];
        if (sup_found) begin
          sup_d   = sup_c;
          state_d = C2C;
        end else begin
          snp_d   = 1'b1;
          state_d = DRD;
        end
      end
      INV:     data_cpl = 1'b1;
      default: state_d = IDLE;
    endcase
    if (data_cpl) begin
      state_d  = IDLE;
      rrd_d    = wrap_inc(gnt_q);
      dcount_d = !(|iREN) ? '0 :
                 (dcount_q == DCW'(DSTARVE)) ? dcount_q : dcount_q + 1'b1;
    end
  end

  always_comb begin
    iwait       = '1;
    dwait       = '1;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    snoop_on    = 1'b0;
    snoop_inv   = 1'b0;
    for (int i = 0; i < CPUS; i++) begin
      iload[i] = ramload;
      dload[i] = ramload;
    end
    case (state_q)
      IRD: begin
        ramREN  = 1'b1;
        ramaddr = iaddr[gnt_q];
        if (done) iwait[gnt_q] = 1'b0;
      end
      DRD: begin
        ramREN    = 1'b1;
        ramaddr   = daddr[gnt_q];
        snoop_on  = snp_q;
        snoop_inv = inv_q;
        if (done) dwait[gnt_q] = 1'b0;
      end
      DWB: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr[gnt_q];
        ramstore = dstore[gnt_q];
        if (done) dwait[gnt_q] = 1'b0;
      end
      SNOOP: begin
        snoop_on  = 1'b1;
        snoop_inv = ccwrite[gnt_q];
      end
      C2C: begin
        // Supplier's line goes to the requester and to RAM in the same op.
        snoop_on     = 1'b1;
        snoop_inv    = inv_q;
        ramWEN       = 1'b1;
        ramaddr      = daddr[gnt_q];
        ramstore     = dstore[sup_q];
        dload[gnt_q] = dstore[sup_q];
        if (done) begin
          dwait[gnt_q] = 1'b0;
          dwait[sup_q] = 1'b0;
        end
      end
      INV: begin
        snoop_on     = 1'b1;
        snoop_inv    = 1'b1;
        dwait[gnt_q] = 1'b0;
      end
      default: ;
    endcase
    for (int i = 0; i < CPUS; i++) begin
      if (snoop_on && i != int'(gnt_q)) begin
        ccwait[i]      = 1'b1;
        ccinv[i]       = snoop_inv;
        ccsnoopaddr[i] = daddr[gnt_q];
      end
    end
  end
endmodule

// File: tb/tb_coherent_bus_arbiter.sv
module tb_coherent_bus_arbiter;
  import cpu_types_pkg::*;
  localparam int CPUS = 4, WORD_W = 32, DSTARVE = 4;

  logic CLK = 1'b0, nRST;
  logic [3:0] iREN, dREN, dWEN, cctrans, ccwrite;
  logic [3:0][31:0] iaddr, daddr, dstore;
  logic [3:0] iwait, dwait, ccwait, ccinv;
  logic [3:0][31:0] iload, dload, ccsnoopaddr;
  ramstate_t ramstate;
  logic [31:0] ramload, ramaddr, ramstore;
  logic ramREN, ramWEN;
  int checks = 0, errors = 0;

  always #5 CLK = ~CLK;

  coherent_bus_arbiter #(.CPUS(CPUS), .WORD_W(WORD_W), .DSTARVE(DSTARVE)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .cctrans(cctrans), .ccwrite(ccwrite),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload), .ccwait(ccwait),
    .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr), .ramstate(ramstate), .ramload(ramload),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN), .ramWEN(ramWEN));

  // Returns at a falling edge with reset just released and all inputs idle.
  task automatic do_reset();
    nRST = 1'b0;
    iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (iwait !== 4'hF) begin errors++; $display("FAIL reset_iwait got %h exp f", iwait); end
    checks++; if (dwait !== 4'hF) begin errors++; $display("FAIL reset_dwait got %h exp f", dwait); end
    checks++; if (ccwait !== 4'h0) begin errors++; $display("FAIL reset_ccwait got %h exp 0", ccwait); end
    checks++; if (ccinv !== 4'h0) begin errors++; $display("FAIL reset_ccinv got %h exp 0", ccinv); end
    checks++; if (ccsnoopaddr !== '0) begin errors++; $display("FAIL reset_snoopaddr got %h exp 0", ccsnoopaddr); end
    checks++; if ({ramREN, ramWEN} !== 2'b00) begin errors++; $display("FAIL reset_ramen got %b exp 00", {ramREN, ramWEN}); end
    checks++; if (ramaddr !== '0 || ramstore !== '0) begin errors++; $display("FAIL reset_ramaddr got %h/%h exp 0/0", ramaddr, ramstore); end
  endtask

  task automatic test_ifetch_rr();
    int exp_g[5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_iw;
    do_reset();
    iREN = 4'hF;
    for (int c = 0; c < 4; c++) iaddr[c] = 32'h1000 + 32'(c * 4);
    for (int cyc = 0; cyc < 15; cyc++) begin
      if (cyc > 0) @(negedge CLK);
      ramload  = $urandom;
      ramstate = (cyc % 3 == 1) ? BUSY : ((cyc % 3 == 2) ? ACCESS : FREE);
      #1;
      exp_iw = 4'hF;
      if (cyc % 3 == 2) exp_iw[exp_g[cyc/3]] = 1'b0;
      checks++; if (iwait !== exp_iw) begin errors++; $display("FAIL ifetch_iwait cyc %0d got %b exp %b", cyc, iwait, exp_iw); end
      if (cyc % 3 == 1) begin
        checks++; if (ramREN !== 1'b1 || ramaddr !== iaddr[exp_g[cyc/3]]) begin errors++;
          $display("FAIL ifetch_addr cyc %0d got %b/%h exp 1/%h", cyc, ramREN, ramaddr, iaddr[exp_g[cyc/3]]); end
      end
      if (cyc % 3 == 2) begin
        checks++; if (iload[exp_g[cyc/3]] !== ramload) begin errors++;
          $display("FAIL ifetch_iload cyc %0d got %h exp %h", cyc, iload[exp_g[cyc/3]], ramload); end
      end
    end
    iREN = '0;
  endtask

  task automatic test_dwb_then_ifetch();
    do_reset();
    dWEN[2] = 1'b1; daddr[2] = 32'h2000_0040; dstore[2] = 32'h1234_5678;
    iREN[1] = 1'b1; iaddr[1] = 32'h400;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (cyc > 0) @(negedge CLK);
      if (cyc == 3) dWEN = '0;
      ramload  = $urandom;
      ramstate = (cyc % 3 == 1) ? BUSY : ((cyc % 3 == 2) ? ACCESS : FREE);
      #1;
      case (cyc)
        1: begin checks++; if ({ramWEN, ramREN} !== 2'b10 || ramaddr !== 32'h2000_0040 || ramstore !== 32'h1234_5678) begin errors++;
             $display("FAIL dwb_first got wen%b ren%b %h %h exp wen1 ren0 20000040 12345678", ramWEN, ramREN, ramaddr, ramstore); end end
        2: begin checks++; if (dwait !== 4'b1011 || iwait !== 4'hF) begin errors++;
             $display("FAIL dwb_done got d%b i%b exp d1011 i1111", dwait, iwait); end end
        3: begin checks++; if ({ramWEN, ramREN} !== 2'b00) begin errors++; $display("FAIL dwb_idle got %b exp 00", {ramWEN, ramREN}); end end
        4: begin checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h400) begin errors++;
             $display("FAIL ird_second got %b %h exp 1 400", ramREN, ramaddr); end end
        5: begin checks++; if (iwait !== 4'b1101 || iload[1] !== ramload) begin errors++;
             $display("FAIL ird_done got %b %h exp 1101 %h", iwait, iload[1], ramload); end end
        default: ;
      endcase
    end
    iREN = '0;
  endtask

  task automatic test_starvation();
    logic [3:0] exp_iw, exp_dw;
    int ndata = 0;
    do_reset();
    dREN = 4'hF; iREN[1] = 1'b1; iaddr[1] = 32'hC0;
    for (int c = 0; c < 4; c++) daddr[c] = 32'h8000 + 32'(c * 16);
    for (int cyc = 0; cyc < 15; cyc++) begin
      if (cyc > 0) @(negedge CLK);
      ramload  = $urandom;
      ramstate = (cyc % 3 == 1) ? BUSY : ((cyc % 3 == 2) ? ACCESS : FREE);
      #1;
      exp_iw = 4'hF; exp_dw = 4'hF;
      if (cyc % 3 == 2) begin
        if (cyc / 3 < 4) exp_dw[cyc/3] = 1'b0; else exp_iw[1] = 1'b0;
      end
      checks++; if (iwait !== exp_iw || dwait !== exp_dw) begin errors++;
        $display("FAIL starve_waits cyc %0d got i%b d%b exp i%b d%b", cyc, iwait, dwait, exp_iw, exp_dw); end
      if (dwait != 4'hF) ndata++;
      if (iwait[1] === 1'b0) begin
        checks++; if (ndata !== DSTARVE) begin errors++; $display("FAIL starve_count got %0d exp %0d", ndata, DSTARVE); end
      end
    end
    dREN = '0; iREN = '0;
  endtask

  task automatic test_c2c();
    do_reset();
    dREN[0] = 1'b1; cctrans[0] = 1'b1; ccwrite[0] = 1'b1; daddr[0] = 32'h100; dstore[0] = 32'h5555;
    cctrans[3] = 1'b1; ccwrite[3] = 1'b1; dstore[3] = 32'hDEAD;
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (cyc > 0) @(negedge CLK);
      if (cyc == 4) begin dREN = '0; cctrans = '0; ccwrite = '0; end
      ramload  = 32'hBEEF;
      ramstate = (cyc == 2) ? BUSY : ((cyc == 3) ? ACCESS : FREE);
      #1;
      case (cyc)
        1: begin checks++; if (ccwait !== 4'b1110 || ccinv !== 4'b1110 || ccsnoopaddr[3] !== 32'h100 || ccsnoopaddr[0] !== 32'h0) begin errors++;
             $display("FAIL c2c_snoop got w%b i%b a3 %h a0 %h exp w1110 i1110 a3 100 a0 0", ccwait, ccinv, ccsnoopaddr[3], ccsnoopaddr[0]); end end
        2: begin checks++; if (ramWEN !== 1'b1 || ramaddr !== 32'h100 || ramstore !== 32'hDEAD || dload[0] !== 32'hDEAD || ccinv !== 4'b1110 || dwait !== 4'hF) begin errors++;
             $display("FAIL c2c_xfer got wen%b %h %h dl %h inv %b dw %b exp wen1 100 dead dead 1110 1111", ramWEN, ramaddr, ramstore, dload[0], ccinv, dwait); end end
        3: begin checks++; if (dwait !== 4'b0110) begin errors++; $display("FAIL c2c_done got %b exp 0110", dwait); end end
        4: begin checks++; if (ccwait !== 4'h0 || dwait !== 4'hF) begin errors++; $display("FAIL c2c_idle got w%b d%b exp 0000 1111", ccwait, dwait); end end
        default: ;
      endcase
    end
  endtask

  task automatic test_inv();
    do_reset();
    cctrans[1] = 1'b1; daddr[1] = 32'h240;
    for (int cyc = 0; cyc < 3; cyc++) begin
      if (cyc > 0) @(negedge CLK);
      if (cyc == 2) cctrans = '0;
      #1;
      if (cyc == 1) begin
        checks++; if (ccinv !== 4'b1101 || ccwait !== 4'b1101 || {ramREN, ramWEN} !== 2'b00 || dwait !== 4'b1101 || ccsnoopaddr[0] !== 32'h240) begin errors++;
          $display("FAIL inv_cycle got i%b w%b en%b d%b a %h exp 1101 1101 00 1101 240", ccinv, ccwait, {ramREN, ramWEN}, dwait, ccsnoopaddr[0]); end
      end
      if (cyc == 2) begin
        checks++; if (ccinv !== 4'h0 || dwait !== 4'hF) begin errors++; $display("FAIL inv_after got i%b d%b exp 0000 1111", ccinv, dwait); end
      end
    end
  endtask

  task automatic test_error_reset();
    do_reset();
    dREN[0] = 1'b1; daddr[0] = 32'h80;
    for (int cyc = 1; cyc < 6; cyc++) begin
      @(negedge CLK);
      ramstate = ERROR;
      #1;
      checks++; if (dwait !== 4'hF || ramREN !== 1'b1 || ramaddr !== 32'h80) begin errors++;
        $display("FAIL error_hold cyc %0d got d%b ren%b %h exp 1111 1 80", cyc, dwait, ramREN, ramaddr); end
    end
    #1 nRST = 1'b0;
    #1;
    checks++; if ({ramREN, ramWEN} !== 2'b00 || ramaddr !== '0 || dwait !== 4'hF || iwait !== 4'hF || ccwait !== 4'h0) begin errors++;
      $display("FAIL async_reset got en%b %h d%b i%b w%b exp 00 0 1111 1111 0000", {ramREN, ramWEN}, ramaddr, dwait, iwait, ccwait); end
    dREN = '0;
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  // Transaction-level reference: one op at a time, per-class round-robin
  // pointers, and a starvation counter that forces an instruction grant.
  task automatic test_random();
    int busy = 0, cls = 0, core = 0, pd = 0, pi = 0, dc = 0, p;
    logic [3:0] dset, vec, exp_iw, exp_dw;
    logic exp_ren, exp_wen, take_i, done, found;
    logic [31:0] exp_addr, exp_store;
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc > 0) @(negedge CLK);
      for (int c = 0; c < 4; c++) begin
        if (!iREN[c] && $urandom_range(0, 3) == 0) iREN[c] = 1'b1;
        if (!dREN[c] && !dWEN[c] && $urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 1) == 1) dREN[c] = 1'b1; else dWEN[c] = 1'b1;
        end
        iaddr[c] = $urandom; daddr[c] = $urandom; dstore[c] = $urandom;
      end
      ramload  = $urandom;
      ramstate = ramstate_t'($urandom_range(0, 3));
      #1;
      exp_iw = 4'hF; exp_dw = 4'hF; exp_ren = 0; exp_wen = 0; exp_addr = '0; exp_store = '0; done = 0;
      if (busy != 0) begin
        exp_ren  = (cls != 2);
        exp_wen  = (cls == 2);
        exp_addr = (cls == 0) ? iaddr[core] : daddr[core];
        if (cls == 2) exp_store = dstore[core];
        done = (ramstate == ACCESS);
        if (done) begin
          if (cls == 0) exp_iw[core] = 1'b0; else exp_dw[core] = 1'b0;
        end
      end
      checks++; if (iwait !== exp_iw || dwait !== exp_dw) begin errors++;
        $display("FAIL rand_waits cyc %0d got i%b d%b exp i%b d%b", cyc, iwait, dwait, exp_iw, exp_dw); end
      checks++; if (ramREN !== exp_ren || ramWEN !== exp_wen || ramaddr !== exp_addr || ramstore !== exp_store) begin errors++;
        $display("FAIL rand_ram cyc %0d got %b%b %h %h exp %b%b %h %h", cyc, ramREN, ramWEN, ramaddr, ramstore, exp_ren, exp_wen, exp_addr, exp_store); end
      checks++; if (ccwait !== 4'h0) begin errors++; $display("FAIL rand_ccwait cyc %0d got %b exp 0000", cyc, ccwait); end
      if (busy != 0 && cls == 1) begin
        checks++; if (dload[core] !== ramload) begin errors++; $display("FAIL rand_dload cyc %0d got %h exp %h", cyc, dload[core], ramload); end
      end
      if (busy != 0) begin
        if (done) begin
          busy = 0;
          if (cls == 0) begin
            pi = (core + 1) % 4; dc = 0; iREN[core] = 1'b0;
          end else begin
            pd = (core + 1) % 4;
            dc = (iREN == 0) ? 0 : ((dc < DSTARVE) ? dc + 1 : DSTARVE);
            dREN[core] = 1'b0; dWEN[core] = 1'b0;
          end
        end
      end else begin
        dset = dREN | dWEN;
        if ((iREN | dset) != 0) begin
          take_i = (iREN != 0) && (dset == 0 || dc == DSTARVE);
          p   = take_i ? pi : pd;
          vec = take_i ? iREN : dset;
          found = 0;
          for (int k = 0; k < 4; k++) begin
            if (!found && vec[(p + k) % 4]) begin found = 1; core = (p + k) % 4; end
          end
          busy = 1;
          cls  = take_i ? 0 : (dWEN[core] ? 2 : 1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ifetch_rr();
    test_dwb_then_ifetch();
    test_starvation();
    test_c2c();
    test_inv();
    test_error_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
